// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA framebuffer path.
package vga_pkg;

    typedef logic [11:0] color_t;

    // Per-access tag that travels alongside the RAM read latency.
    typedef struct packed {
        logic disp;
        logic rd;
        logic oob;
    } tag_t;

    // Linear framebuffer address of pixel (x, y) for a row width of w pixels.
    function automatic logic [31:0] fb_addr(input logic [15:0] x, input logic [15:0] y,
                                            input int unsigned w);
        return (32'(y) * w) + 32'(x);
    endfunction

endpackage

// File: rtl/vga_fb_rr2.sv
// Two-requester round-robin: the requester not granted last time wins a tie.
module vga_fb_rr2 (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 when the last completed handshake went to requester 1.
    logic last_grant;

    // Remember who won the last completed handshake; after reset requester 0 wins first.
    always_ff @(posedge clk) begin
        if (res) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

    // Grant the lone requester, or the one not served last on a tie.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last_grant);
        grant[1] = req[1] & (~req[0] | ~last_grant);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between display scanout and a CPU port.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter int unsigned ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              res,
    input  logic              disp_req,
    input  logic [15:0]       disp_x,
    input  logic [15:0]       disp_y,
    output color_t            disp_color,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  color_t            wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output color_t            rd_data,
    output logic              rd_rvalid,
    output logic              oob_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output color_t            mem_wdata,
    input  color_t            mem_rdata
);

    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    logic [1:0]        grant;
    logic              cpu_slot_c;
    logic              wr_hs_c;
    logic              rd_hs_c;
    logic              disp_in_c;
    logic              wr_oob_c;
    logic              rd_oob_c;
    logic [ADDR_W-1:0] disp_addr_c;
    tag_t              tag0;
    tag_t              tag1;

    vga_fb_rr2 u_rr (
        .clk     (clk),
        .res     (res),
        .req     ({rd_valid, wr_valid}),
        .advance (wr_hs_c | rd_hs_c),
        .grant   (grant)
    );

    // Slot decision: display owns the cycle outright, otherwise CPU ports share it.
    always_comb begin
        cpu_slot_c  = ~res & ~disp_req;
        wr_ready    = cpu_slot_c & (~rd_valid | grant[0]);
        rd_ready    = cpu_slot_c & (~wr_valid | grant[1]);
        wr_hs_c     = wr_valid & wr_ready;
        rd_hs_c     = rd_valid & rd_ready;
        disp_in_c   = (32'(disp_x) < FB_WIDTH) && (32'(disp_y) < FB_HEIGHT);
        disp_addr_c = ADDR_W'(fb_addr(disp_x, disp_y, FB_WIDTH));
        wr_oob_c    = 32'(wr_addr) >= FB_PIXELS;
        rd_oob_c    = 32'(rd_addr) >= FB_PIXELS;
    end

    // Issue register, two-stage tag pipeline and return steering.
    always_ff @(posedge clk) begin
        if (res) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tag0       <= '0;
            tag1       <= '0;
            disp_valid <= 1'b0;
            disp_color <= '0;
            rd_rvalid  <= 1'b0;
            rd_data    <= '0;
            oob_err    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            tag0   <= '0;
            if (disp_req) begin
                // Off-screen pixels skip the RAM but still return black in order.
                tag0 <= '{disp: 1'b1, rd: 1'b0, oob: ~disp_in_c};
                if (disp_in_c) begin
                    mem_en   <= 1'b1;
                    mem_addr <= disp_addr_c;
                end
            end else if (wr_hs_c) begin
                if (wr_oob_c) begin
                    oob_err <= 1'b1;
                end else begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
            end else if (rd_hs_c) begin
                tag0 <= '{disp: 1'b0, rd: 1'b1, oob: rd_oob_c};
                if (rd_oob_c) begin
                    oob_err <= 1'b1;
                end else begin
                    mem_en   <= 1'b1;
                    mem_addr <= rd_addr;
                end
            end

            tag1       <= tag0;
            disp_valid <= tag1.disp;
            disp_color <= (tag1.disp && !tag1.oob) ? mem_rdata : '0;
            rd_rvalid  <= tag1.rd;
            if (tag1.rd) begin
                rd_data <= tag1.oob ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter against a transaction-level model.
module tb_vga_fb_arbiter;

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int PIX = W * H;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        disp_req = 1'b0;
    logic [15:0] disp_x = '0;
    logic [15:0] disp_y = '0;
    logic [11:0] disp_color;
    logic        disp_valid;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [18:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [18:0] rd_addr = '0;
    logic [11:0] rd_data;
    logic        rd_rvalid;
    logic        oob_err;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .res        (res),
        .disp_req   (disp_req),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .disp_color (disp_color),
        .disp_valid (disp_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_rvalid  (rd_rvalid),
        .oob_err    (oob_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Write-first single-port RAM with one cycle of read latency.
    logic [11:0] ram [0:(1<<19)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Model: expected picture of the framebuffer and of every output after an edge.
    typedef struct {
        bit          disp;
        bit          rd;
        logic [11:0] data;
    } ent_t;

    logic [11:0] shadow [int];
    ent_t        pipe [$];
    bit          m_wr_last;
    bit          m_oob;
    bit          m_en, m_we, m_dv, m_rv;
    logic [18:0] m_addr;
    logic [11:0] m_wdata, m_dc, m_rd;
    bit          seen_wr_ready, seen_rd_ready;

    function automatic logic [11:0] fb_read(input int a);
        return shadow.exists(a) ? shadow[a] : 12'h000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t none;
        none = '{disp: 1'b0, rd: 1'b0, data: 12'h000};
        pipe = {none, none};
        m_wr_last = 1'b0;
        m_oob = 1'b0;
        m_en = 1'b0; m_we = 1'b0; m_dv = 1'b0; m_rv = 1'b0;
        m_addr = '0; m_wdata = '0; m_dc = '0; m_rd = '0;
    endtask

    // One clock: drive, check grants, step the model across the edge, compare outputs.
    task automatic step(input bit r, input bit dq, input int dx, input int dy,
                        input bit wv, input int wa, input int wd, input bit rv, input int ra);
        bit   exp_wr, exp_rd, wr_hs, rd_hs;
        ent_t e, o;
        int   a;
        @(negedge clk);
        res = r; disp_req = dq;
        disp_x = 16'(dx); disp_y = 16'(dy);
        wr_valid = wv; wr_addr = 19'(wa); wr_data = 12'(wd);
        rd_valid = rv; rd_addr = 19'(ra);
        #1;
        // With both CPU ports pending, the one that did not win last time goes first.
        exp_wr = !r && !dq && (!rv || !m_wr_last);
        exp_rd = !r && !dq && (!wv || m_wr_last);
        seen_wr_ready = wr_ready;
        seen_rd_ready = rd_ready;
        if (wv || r) chk("wr_ready", 32'(wr_ready), 32'(exp_wr));
        if (rv || r) chk("rd_ready", 32'(rd_ready), 32'(exp_rd));
        wr_hs = wv && exp_wr;
        rd_hs = rv && exp_rd;

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            e = '{disp: 1'b0, rd: 1'b0, data: 12'h000};
            m_en = 1'b0; m_we = 1'b0;
            if (dq) begin
                e.disp = 1'b1;
                if (dx < W && dy < H) begin
                    a = dy * W + dx;
                    e.data = fb_read(a);
                    m_en = 1'b1; m_addr = 19'(a);
                end
            end else if (wr_hs) begin
                m_wr_last = 1'b1;
                if (wa >= PIX) m_oob = 1'b1;
                else begin
                    shadow[wa] = 12'(wd);
                    m_en = 1'b1; m_we = 1'b1; m_addr = 19'(wa); m_wdata = 12'(wd);
                end
            end else if (rd_hs) begin
                m_wr_last = 1'b0;
                e.rd = 1'b1;
                if (ra >= PIX) m_oob = 1'b1;
                else begin
                    e.data = fb_read(ra);
                    m_en = 1'b1; m_addr = 19'(ra);
                end
            end
            pipe.push_back(e);
            o = pipe.pop_front();
            m_dv = o.disp;
            m_dc = o.disp ? o.data : 12'h000;
            m_rv = o.rd;
            if (o.rd) m_rd = o.data;
        end
        #1;
        chk("mem_en", 32'(mem_en), 32'(m_en));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we || r) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("disp_valid", 32'(disp_valid), 32'(m_dv));
        chk("disp_color", 32'(disp_color), 32'(m_dc));
        chk("rd_rvalid", 32'(rd_rvalid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("oob_err", 32'(oob_err), 32'(m_oob));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n, input bit wv);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, wv, 7, 12'h111, 0, 0);
    endtask

    initial begin
        int dx, dy, wa, ra;
        bit r, dq, wv, rv;
        for (int i = 0; i < (1 << 19); i++) ram[i] = 12'h000;
        model_reset();

        // Reset held three cycles with a pending write.
        do_reset(3, 1'b1);
        chk("reset_mem_en", 32'(mem_en), 32'h0);
        chk("reset_oob", 32'(oob_err), 32'h0);

        // Display priority over a pending write.
        step(0, 0, 0, 0, 1, 1285, 12'h5A3, 0, 0);
        step(0, 1, 5, 2, 1, 1285, 12'h777, 0, 0);
        chk("prio_wr_ready", 32'(seen_wr_ready), 32'h0);
        chk("prio_mem_addr", 32'(mem_addr), 32'd1285);
        idle(2);
        chk("prio_disp_valid", 32'(disp_valid), 32'h1);
        chk("prio_disp_color", 32'(disp_color), 32'h5A3);

        // Round-robin alternation starting with the write after reset.
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 10, 12'h010 + i, 1, 20);
            chk("rr_wr", 32'(seen_wr_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_rd", 32'(seen_rd_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        idle(2);

        // Write then read of the same address.
        step(0, 0, 0, 0, 1, 100, 12'hABC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_rd_early", 32'(rd_rvalid), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wr_rd_valid", 32'(rd_rvalid), 32'h1);
        chk("wr_rd_data", 32'(rd_data), 32'hABC);

        // Off-screen pixel and out-of-range write.
        step(0, 1, 640, 0, 0, 0, 0, 0, 0);
        chk("oob_disp_en", 32'(mem_en), 32'h0);
        idle(2);
        chk("oob_disp_valid", 32'(disp_valid), 32'h1);
        chk("oob_disp_color", 32'(disp_color), 32'h0);
        step(0, 0, 0, 0, 1, 307200, 12'hFFF, 0, 0);
        chk("oob_wr_ready", 32'(seen_wr_ready), 32'h1);
        chk("oob_wr_en", 32'(mem_en), 32'h0);
        chk("oob_err_set", 32'(oob_err), 32'h1);
        idle(3);
        chk("oob_err_sticky", 32'(oob_err), 32'h1);
        do_reset(1, 1'b0);
        chk("oob_err_clr", 32'(oob_err), 32'h0);

        // Read in flight when reset hits: it must never return.
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 100);
        do_reset(1, 1'b0);
        idle(1);
        chk("flush_no_rvalid", 32'(rd_rvalid), 32'h0);
        step(0, 0, 0, 0, 1, 30, 12'h333, 1, 31);
        chk("flush_wr_first", 32'(seen_wr_ready), 32'h1);
        idle(3);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            dq = ($urandom_range(0, 99) < 35);
            dx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 700)) : int'($urandom_range(0, 639));
            case ($urandom_range(0, 9))
                0:       dy = int'($urandom_range(480, 520));
                1, 2:    dy = int'($urandom_range(0, 479));
                default: dy = int'($urandom_range(0, 3));
            endcase
            wv = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 6);
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(307200, 524287)) : int'($urandom_range(0, 2559));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(307200, 524287)) : int'($urandom_range(0, 2559));
            step(r, dq, dx, dy, wv, wa, int'($urandom_range(0, 4095)), rv, ra);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
